reg_write_arbiter: RTL
======================

# reg_write_arbiter

Shares the load port of a bank of `Reg1`-style registers between several requesters. Each cycle it picks one pending write request round-robin and drives the matching one-hot `ld` strobe and write data into the register bank. It acknowledges the winning requester in the same cycle. It sits between the control/execute sources and the register bank, so `Reg1` instances never see more than one `ld` per cycle.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `NREG`, 8: number of registers in the bank.
- `DW`, 1: register data width.
- `AW`, `$clog2(NREG)`: register address width. This is derived; do not override it.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester write request.
- `addr` in NREQ*AW: per-requester target register. Requester k uses slice [k*AW +: AW].
- `data` in NREQ*DW: per-requester write data. Requester k uses slice [k*DW +: DW].
- `lock` in NREQ: per-requester burst lock. Present only with `REG_ARB_LOCK_EN`.
- `ack` out NREQ: one-hot, one-cycle acknowledge to the granted requester.
- `ld` out NREG: one-hot load strobe to the register bank.
- `wdata` out DW: data for the register selected by `ld`.
- `err` out 1: one-cycle pulse when a granted address is ≥ NREG.
- `busy` out 1: high while a write is being issued (state ISSUE).

## Operation
- **FSM states:** IDLE and ISSUE.
  - IDLE → ISSUE at any edge with an eligible request.
  - ISSUE → ISSUE if another eligible request exists, otherwise IDLE.
- **Eligibility:** `req[k]=1` and not masked. Requester k is masked in the cycle its `ack[k]` is high, unless it holds a lock.
- **Round-robin:**
  - Search starts at pointer `ptr` (0..NREQ-1) and the first eligible index wins.
  - After granting k, `ptr` becomes (k+1) mod NREQ.
- **Capture:** at the edge, register the winner's `addr`/`data` and the winner index.
- **ISSUE cycle outputs:**
  - `ld[addr]=1`, `wdata=data`, `ack[winner]=1`, `busy=1`.
  - If addr ≥ NREG: `ld` is all zero, `err=1`, and `ack` is still asserted, so the requester is not stalled.
- **Requester contract:**
  - Hold `req`/`addr`/`data` stable until `ack` is seen.
  - During the `ack` cycle, either drop `req` or present the next write.
- **Throughput:** one write per cycle across all requesters. A single unlocked requester gets at most one write every 2 cycles.

## Timing
- **Reset (asynchronous, `rst_n` low):**
  - `ack`, `ld`, `wdata`, `err`, `busy` all 0.
  - `ptr`=0, state IDLE, lock counter 0.
  - Assertion during ISSUE clears `ld` immediately; the write is lost, with no `ack`.
- **Latency:** a request sampled at edge E produces `ld`/`ack` in the cycle after E, i.e. they are registered outputs visible until edge E+1.
- **Bank load:** the `Reg1` bank loads `wdata` at edge E+1.
- **Registered outputs:** all outputs are flop outputs, with no combinational path from inputs.
- **Simultaneous requests:** all NREQ requesting at once are served in `ptr` order, one per cycle, with no starvation. The worst-case wait is NREQ cycles without lock.
- **Pointer wrap:** a grant to NREQ-1 sets `ptr`=0.
- **Dropped request:** `req` dropped before being granted is ignored; nothing is latched.

## Configuration
- **`REG_ARB_LOCK_EN` defined:**
  - The `lock` port exists.
  - If the granted requester k has `lock[k]=1`, it is not masked, and `ptr` stays at k, so k wins back-to-back.
  - A counter limits the run to `LOCK_MAX` (4) consecutive grants. After that, `ptr` advances to k+1 regardless of `lock`, and the counter clears.
  - The counter also clears on any grant to a different requester.
- **`REG_ARB_LOCK_EN` undefined:**
  - There is no `lock` port and no counter.
  - Behaviour is pure round-robin as above.

## Structure
- **Package `reg_arb_pkg`:**
  - State enum `arb_state_t` {IDLE, ISSUE}.
  - Constant `LOCK_MAX`=4.
  - Function `onehot_dec(addr, NREG)`.
- **Sub-module `rr_picker`:** combinational; inputs are the eligible vector and `ptr`; outputs are `found` and the winner index.
- The top level holds the FSM, pointer, capture registers, lock counter and output flops.

## Test plan
- **Reset and single write:** reset, release, then `req[1]`=1 with addr=3, data=1 → `ld`=8'b0000_1000, `wdata`=1, `ack`=4'b0010 one cycle later. The bank's reg 3 reads 1 afterwards.
- **All requesting:** all four `req` high, `ptr`=0 → `ack` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with `busy` continuously high.
- **Unlocked repeat:** `req[2]` held high alone for 6 cycles → `ack[2]` on alternate cycles only (3 writes).
- **Bad address:** NREG=6, `req[0]` with addr=7 → `ld`=0, `err`=1, `ack`=0001 in the same cycle.
- **Lock run (`REG_ARB_LOCK_EN`):** `req[0]`,`lock[0]`,`req[1]` held → `ack[0]` for 4 consecutive cycles, then `ack[1]`.
- **Mid-operation reset:** `rst_n` pulled low during ISSUE → `ld`/`ack` drop to 0 without waiting for `clk`, and the target register is unchanged.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    localparam int unsigned LOCK_MAX = 4;
    localparam int unsigned MAX_NREG = 64;

    // One-hot decode of a register address; all zero when addr is outside the bank.
    function automatic logic [MAX_NREG-1:0] onehot_dec(input logic [31:0] addr,
                                                       input int unsigned nreg);
        onehot_dec = '0;
        if (addr < nreg) begin
            onehot_dec[addr[5:0]] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side and register-bank-side signals of reg_write_arbiter.
// The lock port exists only when REG_ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 1
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] data;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif
    logic [NREQ-1:0]    ack;
    logic [NREG-1:0]    ld;
    logic [DW-1:0]      wdata;
    logic               err;
    logic               busy;

    modport master (
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        output req, addr, data,
        input  ack, ld, wdata, err, busy
    );

    modport slave (
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        input  req, addr, data,
        output ack, ld, wdata, err, busy
    );

endinterface

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible index at or after ptr.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    int unsigned cand;

    // Walk from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = (32'(ptr) + 32'(i)) % NREQ;
            if (elig[IW'(cand)]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the load port of a register bank between requesters.
// Optional burst lock with bounded run length is enabled by REG_ARB_LOCK_EN.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_write_arbiter_if.slave bus
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state, state_nx;
    logic [IW-1:0]     ptr, ptr_nx, ptr_inc_c;
    logic [NREQ-1:0]   elig_c;
    logic              found_c;
    logic [IW-1:0]     win_c;
    logic [AW-1:0]     win_addr_c;
    logic [DW-1:0]     win_data_c;
    logic [NREQ-1:0]   ack_c;
    logic [NREG-1:0]   ld_c;
    logic              err_c;

`ifdef REG_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] cnt, cnt_nx, run_c;
    logic [IW-1:0] cap_idx;

    // A locked requester stays eligible through its own ack cycle.
    assign elig_c = bus.req & ~(bus.ack & ~bus.lock);
    assign run_c  = (cap_idx == win_c) ? cnt + CW'(1) : CW'(1);
`else
    assign elig_c = bus.req & ~bus.ack;
`endif

    rr_picker #(.NREQ(NREQ)) u_picker (
        .elig  (elig_c),
        .ptr   (ptr),
        .found (found_c),
        .idx   (win_c)
    );

    assign ptr_inc_c = (32'(win_c) == NREQ - 1) ? '0 : win_c + IW'(1);

    // Winner's address/data mux.
    always_comb begin
        win_addr_c = '0;
        win_data_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == win_c) begin
                win_addr_c = bus.addr[k*AW +: AW];
                win_data_c = bus.data[k*DW +: DW];
            end
        end
    end

    // Next-cycle output values.
    always_comb begin
        ack_c = '0;
        ld_c  = '0;
        err_c = 1'b0;
        if (found_c) begin
            ack_c[win_c] = 1'b1;
            ld_c         = NREG'(onehot_dec(32'(win_addr_c), NREG));
            err_c        = (32'(win_addr_c) >= NREG);
        end
    end

    // Next state and pointer.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
`ifdef REG_ARB_LOCK_EN
        cnt_nx   = '0;
`endif
        case (state)
            IDLE:    state_nx = found_c ? ISSUE : IDLE;
            ISSUE:   state_nx = found_c ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
        if (found_c) begin
            ptr_nx = ptr_inc_c;
`ifdef REG_ARB_LOCK_EN
            if (bus.lock[win_c] && (32'(run_c) < LOCK_MAX)) begin
                ptr_nx = win_c;
                cnt_nx = run_c;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            bus.ack   <= '0;
            bus.ld    <= '0;
            bus.wdata <= '0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
`ifdef REG_ARB_LOCK_EN
            cnt       <= '0;
            cap_idx   <= '0;
`endif
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            bus.ack   <= ack_c;
            bus.ld    <= ld_c;
            bus.wdata <= found_c ? win_data_c : '0;
            bus.err   <= err_c;
            bus.busy  <= (state_nx == ISSUE);
`ifdef REG_ARB_LOCK_EN
            cnt       <= cnt_nx;
            if (found_c) begin
                cap_idx <= win_c;
            end
`endif
        end
    end

endmodule
